alu_rr_scheduler: RTL

Shares one 8-bit combinational ALU among NUM_REQ requesters using round-robin arbitration with valid/ready handshakes on both sides. It registers the selected ALU result into a one-entry output buffer, tagged with the winning requester ID. It sits between the issuing agents and the consumer of ALU results.

---
 rtl/alu_sched_pkg.sv | 15 +
 rtl/alu.sv | 24 ++
 rtl/rr_arbiter.sv | 27 ++
 rtl/alu_rr_scheduler.sv | 89 ++++++++
 4 files changed

// File: rtl/alu_sched_pkg.sv
// alu_sched_pkg: shared types and constants for the round-robin ALU scheduler.
package alu_sched_pkg;
  localparam int DATA_W = 8;
  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_SLL = 3'b010,
    OP_LSR = 3'b011,
    OP_AND = 3'b100,
    OP_OR  = 3'b101,
    OP_XOR = 3'b110,
    OP_EQL = 3'b111
  } alu_op_t;
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} sched_state_t;
endpackage

// File: rtl/alu.sv
// alu: 8-bit combinational ALU; shifts use b[2:0], add/sub wrap modulo 2^8.
module alu
  import alu_sched_pkg::*;
(
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  alu_op_t           op_i,
  output logic [DATA_W-1:0] y_o
);
  always_comb begin
    y_o = '0;
    case (op_i)
      OP_ADD:  y_o = a_i + b_i;
      OP_SUB:  y_o = a_i - b_i;
      OP_SLL:  y_o = a_i << b_i[2:0];
      OP_LSR:  y_o = a_i >> b_i[2:0];
      OP_AND:  y_o = a_i & b_i;
      OP_OR:   y_o = a_i | b_i;
      OP_XOR:  y_o = a_i ^ b_i;
      OP_EQL:  y_o = {{(DATA_W-1){1'b0}}, a_i == b_i};
      default: y_o = '0;
    endcase
  end
endmodule

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin grant search starting at ptr_i and wrapping upward.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    ptr_i,
  input  logic               en_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [ID_W-1:0]    gnt_idx_o
);
  logic            found;
  logic [ID_W-1:0] j;
  always_comb begin
    found     = 1'b0;
    j         = '0;
    gnt_idx_o = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      j = ID_W'((int'(ptr_i) + i) % NUM_REQ);
      if (!found && req_i[j]) begin
        found     = 1'b1;
        gnt_idx_o = j;
      end
    end
    gnt_o = (en_i && found) ? (NUM_REQ'(1) << gnt_idx_o) : '0;
  end
endmodule

// File: rtl/alu_rr_scheduler.sv
// alu_rr_scheduler: shares one ALU among NUM_REQ requesters with a one-entry result buffer.
// Define ALU_STATS_EN to add saturating op/stall counters.
module alu_rr_scheduler
  import alu_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                            clk,
  input  logic                            reset_n,
`ifdef ALU_STATS_EN
  output logic [15:0]                     op_cnt_o,
  output logic [15:0]                     stall_cnt_o,
`endif
  input  logic [NUM_REQ-1:0]              req_valid_i,
  output logic [NUM_REQ-1:0]              req_ready_o,
  input  logic [NUM_REQ-1:0][DATA_W-1:0]  req_a_i,
  input  logic [NUM_REQ-1:0][DATA_W-1:0]  req_b_i,
  input  logic [NUM_REQ-1:0][2:0]         req_op_i,
  output logic                            rsp_valid_o,
  input  logic                            rsp_ready_i,
  output logic [DATA_W-1:0]               rsp_data_o,
  output logic [ID_W-1:0]                 rsp_id_o
);
  sched_state_t       state_q, state_d;
  logic [ID_W-1:0]    ptr_q, ptr_d, id_q, id_d, gnt_idx;
  logic [DATA_W-1:0]  data_q, data_d, alu_y;
  logic [NUM_REQ-1:0] gnt;
  logic               can_accept, gnt_any;
  // reset_n gates acceptance so no handshake completes while reset is held
  assign can_accept  = reset_n & ((state_q == EMPTY) | rsp_ready_i);
  assign gnt_any     = |gnt;
  assign req_ready_o = gnt;
  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
    .req_i     (req_valid_i),
    .ptr_i     (ptr_q),
    .en_i      (can_accept),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx)
  );
  alu u_alu (
    .a_i  (req_a_i[gnt_idx]),
    .b_i  (req_b_i[gnt_idx]),
    .op_i (alu_op_t'(req_op_i[gnt_idx])),
    .y_o  (alu_y)
  );
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= EMPTY;
      ptr_q   <= '0;
      id_q    <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      data_q  <= data_d;
    end
  end
  always_comb begin
    state_d = gnt_any ? FULL : (rsp_ready_i ? EMPTY : state_q);
    ptr_d   = gnt_any ? ((int'(gnt_idx) == NUM_REQ-1) ? '0 : gnt_idx + 1'b1) : ptr_q;
    id_d    = gnt_any ? gnt_idx : id_q;
    data_d  = gnt_any ? alu_y : data_q;
  end
  always_comb begin
    rsp_valid_o = (state_q == FULL);
    rsp_data_o  = data_q;
    rsp_id_o    = id_q;
  end
`ifdef ALU_STATS_EN
  logic [15:0] op_cnt_q, op_cnt_d, stall_cnt_q, stall_cnt_d;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_cnt_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      op_cnt_q    <= op_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end
  always_comb begin
    op_cnt_d    = op_cnt_q + 16'((gnt_any && op_cnt_q != '1) ? 1 : 0);
    stall_cnt_d = stall_cnt_q + 16'((rsp_valid_o && !rsp_ready_i && stall_cnt_q != '1) ? 1 : 0);
  end
  assign op_cnt_o    = op_cnt_q;
  assign stall_cnt_o = stall_cnt_q;
`endif
endmodule
